// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect input and
// the decode-side valid/ready output. The fetch unit uses 'master', its environment 'slave'.
interface instr_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [6:0]  if_opcode;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, if_opcode,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, if_opcode,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           if_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: in-order word fetch with at most one outstanding request,
// a small instruction queue toward decode, and flush/restart on redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master bus
);
  localparam int unsigned AW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_MASK   = 32'hFFFF_FFFC;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0] pc_mem    [QUEUE_DEPTH];
  logic [31:0] instr_mem [QUEUE_DEPTH];

  logic          outstanding;
  logic          head_valid;
  logic          pop;
  logic          push;
  logic          space;
  logic          req_valid;
  logic          accept;
  logic [CW-1:0] count_post_pop;
  logic [CW:0]   occupancy;
  logic [31:0]   head_instr;

  assign outstanding    = (state_q != ST_FETCH);
  assign head_valid     = (count_q != '0);
  assign pop            = head_valid && bus.if_ready;
  assign count_post_pop = count_q - CW'(pop);

  // An outstanding request already owns a queue slot, so it counts against free space.
  assign occupancy = {1'b0, count_post_pop} + (CW+1)'(outstanding);
  assign space     = occupancy < (CW+1)'(QUEUE_DEPTH);

  assign req_valid = !rst && !bus.redirect_valid && space &&
                     ((state_q == ST_FETCH) || ((state_q == ST_WAIT) && bus.imem_rsp_valid));
  assign accept    = req_valid && bus.imem_req_ready;
  assign push      = (state_q == ST_WAIT) && bus.imem_rsp_valid && !bus.redirect_valid;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & PC_MASK;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      // A request still in flight must have its response swallowed later.
      state_d    = (outstanding && !bus.imem_rsp_valid) ? ST_DROP : ST_FETCH;
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        req_pc_d   = fetch_pc_q;
        state_d    = ST_WAIT;
      end else if (outstanding && bus.imem_rsp_valid) begin
        state_d = ST_FETCH;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_post_pop + CW'(push);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC & PC_MASK;
      req_pc_q   <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  generate
    for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_q == AW'(gi))) begin
          pc_mem[gi]    <= req_pc_q;
          instr_mem[gi] <= bus.imem_rsp_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && (count_post_pop == CW'(QUEUE_DEPTH))));
    end
  end

  // Empty queue presents a NOP at PC 0 so decode never sees stale data.
  assign head_instr        = head_valid ? instr_mem[rd_ptr_q] : NOP_INSTR;
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.if_valid       = head_valid;
  assign bus.if_pc          = head_valid ? pc_mem[rd_ptr_q] : 32'h0000_0000;
  assign bus.if_instr       = head_instr;
  assign bus.if_opcode      = head_instr[6:0];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed scenarios followed by random traffic, checked against a stream-level model
// (expected PC sequence, queue occupancy, one-request memory).
module tb_instr_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus();
  instr_fetch_unit_if bus_hi();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(2)) dut_hi (
    .clk(clk), .rst(rst), .bus(bus_hi)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic        redir_v, if_rdy, req_rdy, rand_mode;
  logic [31:0] redir_pc;
  int          mem_lat;

  bit          mem_pend, mem_stale;
  logic [31:0] mem_addr;
  int          mem_cd;

  logic [31:0] m_fetch_pc, m_next_pc;
  int          m_qcount;

  logic        s_req_valid, s_if_valid, s_accept, s_pop, s_rsp;
  logic [31:0] s_req_addr, s_if_pc, s_if_instr;
  logic        prev_stall;
  logic [31:0] prev_addr;

  bit          hi_pend;
  logic [31:0] hi_pend_addr;
  logic [31:0] hi_addr [3];
  int          hi_n;

  bit          got, seen_a, seen_p;
  logic [31:0] first_addr, first_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fetch_pc = 32'h0;
    m_next_pc  = 32'h0;
    m_qcount   = 0;
    prev_stall = 1'b0;
    if (mem_pend) mem_stale = 1'b1;
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic run_cycle();
    bit          rsp_now, rsp_stale;
    logic [31:0] rsp_addr;
    rsp_now = 1'b0; rsp_stale = 1'b0; rsp_addr = 32'h0;
    if (mem_pend && mem_cd == 0) begin
      rsp_now = 1'b1; rsp_stale = mem_stale; rsp_addr = mem_addr; mem_pend = 1'b0;
    end else if (mem_pend) begin
      mem_cd--;
    end
    bus.imem_rsp_valid = rsp_now;
    bus.imem_rsp_data  = rsp_now ? mem_word(rsp_addr) : $urandom();
    bus.imem_req_ready = req_rdy;
    bus.redirect_valid = redir_v;
    bus.redirect_pc    = redir_pc;
    bus.if_ready       = if_rdy;
    bus_hi.imem_rsp_valid = hi_pend;
    bus_hi.imem_rsp_data  = mem_word(hi_pend_addr);
    bus_hi.imem_req_ready = 1'b1;
    bus_hi.redirect_valid = 1'b0;
    bus_hi.redirect_pc    = 32'h0;
    bus_hi.if_ready       = 1'b1;
    #1;
    s_req_valid = bus.imem_req_valid;
    s_req_addr  = bus.imem_req_addr;
    s_if_valid  = bus.if_valid;
    s_if_pc     = bus.if_pc;
    s_if_instr  = bus.if_instr;
    s_rsp       = rsp_now;
    s_accept    = bus.imem_req_valid && req_rdy;
    s_pop       = bus.if_valid && if_rdy;
    if (rst) begin
      check("rst_req_valid", s_req_valid, 32'h0);
      check("rst_if_valid", s_if_valid, 32'h0);
      check("rst_if_pc", s_if_pc, 32'h0);
      check("rst_if_instr", s_if_instr, NOP);
      check("rst_if_opcode", bus.if_opcode, 32'h13);
      model_reset();
    end else begin
      check("if_valid", s_if_valid, m_qcount != 0);
      if (prev_stall && !redir_v) begin
        check("req_hold_valid", s_req_valid, 32'h1);
        check("req_hold_addr", s_req_addr, prev_addr);
      end
      if (s_accept) begin
        check("one_outstanding", mem_pend, 32'h0);
        check("req_addr", s_req_addr, m_fetch_pc);
        m_fetch_pc = m_fetch_pc + 32'd4;
        mem_pend   = 1'b1;
        mem_stale  = 1'b0;
        mem_addr   = s_req_addr;
        mem_cd     = (rand_mode ? int'($urandom_range(1, 3)) : mem_lat) - 1;
      end
      if (s_pop && !redir_v) begin
        check("pop_pc", s_if_pc, m_next_pc);
        check("pop_instr", s_if_instr, mem_word(m_next_pc));
        check("pop_opcode", bus.if_opcode, {25'h0, mem_word(m_next_pc) >> 0} & 32'h7F);
        if (!rand_mode) $display("[TB] deliver pc=%h instr=%h opcode=%h", s_if_pc, s_if_instr, bus.if_opcode);
        m_next_pc = m_next_pc + 32'd4;
        m_qcount--;
      end
      if (rsp_now && !rsp_stale && !redir_v) m_qcount++;
      if (redir_v) begin
        m_fetch_pc = redir_pc & 32'hFFFF_FFFC;
        m_next_pc  = redir_pc & 32'hFFFF_FFFC;
        m_qcount   = 0;
        if (mem_pend) mem_stale = 1'b1;
      end
      prev_stall = s_req_valid && !req_rdy;
      prev_addr  = s_req_addr;
    end
    if (bus_hi.imem_req_valid) begin
      if (hi_n < 3) begin
        hi_addr[hi_n] = bus_hi.imem_req_addr;
        hi_n++;
      end
      hi_pend = 1'b1;
      hi_pend_addr = bus_hi.imem_req_addr;
    end else begin
      hi_pend = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    redir_v = 1'b0; redir_pc = 32'h0; if_rdy = 1'b1; req_rdy = 1'b1; rand_mode = 1'b0;
    mem_lat = 1; mem_pend = 1'b0; mem_stale = 1'b0; mem_addr = 32'h0; mem_cd = 0;
    hi_pend = 1'b0; hi_pend_addr = 32'h0; hi_n = 0;
    for (int i = 0; i < 3; i++) hi_addr[i] = 32'hDEAD_BEEF;
    model_reset();
    @(negedge clk);
    run_cycle();
    run_cycle();
    rst = 1'b0;

    // Back-to-back fetch on a 1-cycle memory.
    for (int i = 0; i < 6; i++) begin
      run_cycle();
      if (i < 4) begin
        check("t1_req_valid", s_req_valid, 32'h1);
        check("t1_req_addr", s_req_addr, 32'(i * 4));
      end
      if (i >= 2) begin
        check("t1_if_valid", s_if_valid, 32'h1);
        check("t1_if_pc", s_if_pc, 32'((i - 2) * 4));
      end else begin
        check("t1_if_latency", s_if_valid, 32'h0);
      end
    end

    // Second instance starting near the top of the address space.
    check("t5_hi_count", hi_n, 32'd3);
    check("t5_hi_addr0", hi_addr[0], 32'hFFFF_FFF8);
    check("t5_hi_addr1", hi_addr[1], 32'hFFFF_FFFC);
    check("t5_hi_addr2", hi_addr[2], 32'h0000_0000);

    // Decode stall fills the queue and stops fetching.
    if_rdy = 1'b0;
    for (int i = 0; i < 10; i++) run_cycle();
    check("t2_queued", m_qcount, 32'd2);
    check("t2_req_valid", s_req_valid, 32'h0);
    check("t2_if_valid", s_if_valid, 32'h1);
    if_rdy = 1'b1;
    for (int i = 0; i < 8; i++) run_cycle();

    // Redirect while a 3-cycle fetch is in flight.
    mem_lat = 3;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      run_cycle();
      got = s_accept;
    end
    check("t3_accept_seen", got, 32'h1);
    run_cycle();
    redir_v = 1'b1; redir_pc = 32'h0000_0103;
    run_cycle();
    redir_v = 1'b0;
    check("t3_redirect_no_req", s_req_valid, 32'h0);
    seen_a = 1'b0; seen_p = 1'b0; first_addr = 32'hDEAD_BEEF; first_pc = 32'hDEAD_BEEF;
    for (int i = 0; i < 12; i++) begin
      run_cycle();
      if (s_accept && !seen_a) begin seen_a = 1'b1; first_addr = s_req_addr; end
      if (s_pop && !seen_p) begin seen_p = 1'b1; first_pc = s_if_pc; end
    end
    check("t3_first_req", first_addr, 32'h0000_0100);
    check("t3_first_if_pc", first_pc, 32'h0000_0100);

    // Redirect coinciding with a response.
    mem_lat = 1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (mem_pend && mem_cd == 0 && !mem_stale) got = 1'b1;
      else run_cycle();
    end
    check("t4_rsp_due", got, 32'h1);
    redir_v = 1'b1; redir_pc = 32'h0000_0200;
    run_cycle();
    redir_v = 1'b0;
    check("t4_rsp_in_redirect", s_rsp, 32'h1);
    run_cycle();
    check("t4_if_valid", s_if_valid, 32'h0);
    check("t4_if_instr_nop", s_if_instr, NOP);
    check("t4_req_valid", s_req_valid, 32'h1);
    check("t4_req_addr", s_req_addr, 32'h0000_0200);

    // Memory back-pressure, then asynchronous reset mid-request.
    req_rdy = 1'b0; if_rdy = 1'b0;
    for (int i = 0; i < 5; i++) run_cycle();
    redir_v = 1'b1; redir_pc = 32'h0000_0300;
    run_cycle();
    redir_v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      check("t6_stall_valid", s_req_valid, 32'h1);
      check("t6_stall_addr", s_req_addr, 32'h0000_0300);
    end
    req_rdy = 1'b1;
    run_cycle();
    check("t6_accept", s_accept, 32'h1);
    mem_lat = 3;
    run_cycle();
    check("t6_back_to_back", s_accept, 32'h1);
    check("t6_back_to_back_addr", s_req_addr, 32'h0000_0304);
    req_rdy = 1'b0;
    check("t6_pre_rst_if_valid", bus.if_valid, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_req_valid", bus.imem_req_valid, 32'h0);
    check("t6_rst_if_valid", bus.if_valid, 32'h0);
    check("t6_rst_if_pc", bus.if_pc, 32'h0);
    check("t6_rst_if_instr", bus.if_instr, NOP);
    check("t6_rst_if_opcode", bus.if_opcode, 32'h13);
    model_reset();
    @(negedge clk);
    run_cycle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) run_cycle();
    check("t6_stray_ignored", s_if_valid, 32'h0);
    req_rdy = 1'b1; if_rdy = 1'b1;
    for (int i = 0; i < 10; i++) run_cycle();

    // Random traffic.
    rand_mode = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      req_rdy  = ($urandom_range(0, 3) != 0);
      if_rdy   = ($urandom_range(0, 9) < 7);
      redir_v  = ($urandom_range(0, 24) == 0);
      redir_pc = $urandom();
      run_cycle();
    end
    redir_v = 1'b0; req_rdy = 1'b1; if_rdy = 1'b1;
    for (int i = 0; i < 20; i++) run_cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
